// File: rtl/fifo_param_if.sv
// Handshake bundle for fifo_param: producer/consumer signals plus status flags.
// The master modport is the side that pushes/pops, the slave modport is the FIFO.
interface fifo_param_if #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data_in;
    logic             data_in_valid;
    logic             pop_fifo;
    logic [WIDTH-1:0] data_out;
    logic             data_out_valid;
    logic             fifo_empty;
    logic             fifo_full;
    logic             almost_full;
    logic [CW-1:0]    count;
    logic             err;

    modport master (
        output data_in, data_in_valid, pop_fifo,
        input  data_out, data_out_valid, fifo_empty, fifo_full,
               almost_full, count, err
    );

    modport slave (
        input  data_in, data_in_valid, pop_fifo,
        output data_out, data_out_valid, fifo_empty, fifo_full,
               almost_full, count, err
    );
endinterface

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO using a circular buffer with explicit pointer
// wrap, so DEPTH need not be a power of two. Supports simultaneous push/pop,
// occupancy count, almost-full flag and a sticky overflow/underflow error.
// Optional macro FIFO_FWFT_EN selects first-word fall-through output;
// otherwise popped data is presented registered one cycle after the pop.
module fifo_param #(
    parameter int WIDTH        = 64,
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = DEPTH - 1
) (
    input logic       clk,
    input logic       rst,
    fifo_param_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wp_r;
    logic [PW-1:0]    rp_r;
    logic [CW-1:0]    count_r;
    logic             empty_r;
    logic             full_r;
    logic             afull_r;
    logic             err_r;

    logic             push_acc_s;
    logic             pop_acc_s;
    logic             err_evt_s;
    logic [CW-1:0]    count_nxt_s;

    // Pointer advance with explicit wrap from DEPTH-1 back to 0.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? PW'(0) : p + PW'(1);
    endfunction

    // Accept decisions: pop needs data; push needs room or a same-cycle pop.
    always_comb begin
        pop_acc_s  = bus.pop_fifo && !empty_r;
        push_acc_s = bus.data_in_valid && (!full_r || pop_acc_s);
        // Dropped push (overflow) or pop on empty (underflow).
        err_evt_s  = (bus.data_in_valid && !push_acc_s) || (bus.pop_fifo && empty_r);
    end

    // Next occupancy: +1 push only, -1 pop only, otherwise unchanged.
    always_comb begin
        count_nxt_s = count_r;
        if (push_acc_s && !pop_acc_s) begin
            count_nxt_s = count_r + CW'(1);
        end else if (pop_acc_s && !push_acc_s) begin
            count_nxt_s = count_r - CW'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Storage array write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (push_acc_s) begin
            mem_r[wp_r] <= bus.data_in;
        end
    end

    // Pointers, count, flags and sticky error; flags come from next count only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_r    <= PW'(0);
            rp_r    <= PW'(0);
            count_r <= CW'(0);
            empty_r <= 1'b1;
            full_r  <= 1'b0;
            afull_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            if (push_acc_s) wp_r <= next_ptr(wp_r);
            if (pop_acc_s)  rp_r <= next_ptr(rp_r);
            count_r <= count_nxt_s;
            empty_r <= (count_nxt_s == CW'(0));
            full_r  <= (count_nxt_s == CW'(DEPTH));
            afull_r <= (count_nxt_s >= CW'(AFULL_THRESH));
            err_r   <= err_r || err_evt_s;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head of queue falls through; zero when empty keeps reset output at 0.
    always_comb begin
        bus.data_out       = empty_r ? {WIDTH{1'b0}} : mem_r[rp_r];
        bus.data_out_valid = !empty_r;
    end
`else
    logic [WIDTH-1:0] dout_r;
    logic             dvalid_r;

    // Capture popped word; valid pulses one cycle per accepted pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_r   <= {WIDTH{1'b0}};
            dvalid_r <= 1'b0;
        end else begin
            if (pop_acc_s) dout_r <= mem_r[rp_r];
            dvalid_r <= pop_acc_s;
        end
    end

    assign bus.data_out       = dout_r;
    assign bus.data_out_valid = dvalid_r;
`endif

    assign bus.fifo_empty  = empty_r;
    assign bus.fifo_full   = full_r;
    assign bus.almost_full = afull_r;
    assign bus.count       = count_r;
    assign bus.err         = err_r;
endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: a DEPTH=4/WIDTH=64 instance and a
// DEPTH=5/WIDTH=8 instance, each with its own reset.
module tb_fifo_param;
    logic clk;
    logic rst_a;
    logic rst_b;
    int   checks;
    int   errors;

    fifo_param_if #(.WIDTH(64), .DEPTH(4)) bus_a ();
    fifo_param_if #(.WIDTH(8),  .DEPTH(5)) bus_b ();

    fifo_param #(.WIDTH(64), .DEPTH(4)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
    fifo_param #(.WIDTH(8),  .DEPTH(5)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step_a(input logic [63:0] din, input logic push, input logic pop);
        bus_a.data_in       = din;
        bus_a.data_in_valid = push;
        bus_a.pop_fifo      = pop;
        @(posedge clk);
        #1;
        bus_a.data_in_valid = 1'b0;
        bus_a.pop_fifo      = 1'b0;
    endtask

    task automatic step_b(input logic [7:0] din, input logic push, input logic pop);
        bus_b.data_in       = din;
        bus_b.data_in_valid = push;
        bus_b.pop_fifo      = pop;
        @(posedge clk);
        #1;
        bus_b.data_in_valid = 1'b0;
        bus_b.pop_fifo      = 1'b0;
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] exp_b;
        int         pushed;
        logic       pu;
        logic       po;
        checks = 0;
        errors = 0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        bus_a.data_in = 64'h0; bus_a.data_in_valid = 1'b0; bus_a.pop_fifo = 1'b0;
        bus_b.data_in = 8'h0;  bus_b.data_in_valid = 1'b0; bus_b.pop_fifo = 1'b0;
        #12;
        check("rst_count", 64'(bus_a.count), 64'd0);
        check("rst_empty", 64'(bus_a.fifo_empty), 64'd1);
        check("rst_full", 64'(bus_a.fifo_full), 64'd0);
        check("rst_afull", 64'(bus_a.almost_full), 64'd0);
        check("rst_err", 64'(bus_a.err), 64'd0);
        check("rst_dout", bus_a.data_out, 64'd0);
        check("rst_dvalid", 64'(bus_a.data_out_valid), 64'd0);
        rst_a = 1'b1;
        rst_b = 1'b1;

`ifdef FIFO_FWFT_EN
        step_a(64'h7, 1'b1, 1'b0);
        check("fwft_dout", bus_a.data_out, 64'h7);
        check("fwft_dvalid", 64'(bus_a.data_out_valid), 64'd1);
        check("fwft_count", 64'(bus_a.count), 64'd1);
        step_a(64'h0, 1'b0, 1'b1);
        check("fwft_empty", 64'(bus_a.fifo_empty), 64'd1);
        check("fwft_dvalid0", 64'(bus_a.data_out_valid), 64'd0);
        check("fwft_err", 64'(bus_a.err), 64'd0);
`else
        // Fill and drain in order.
        step_a(64'h11, 1'b1, 1'b0);
        check("fill1_count", 64'(bus_a.count), 64'd1);
        check("fill1_empty", 64'(bus_a.fifo_empty), 64'd0);
        step_a(64'h22, 1'b1, 1'b0);
        check("fill2_afull", 64'(bus_a.almost_full), 64'd0);
        step_a(64'h33, 1'b1, 1'b0);
        check("fill3_afull", 64'(bus_a.almost_full), 64'd1);
        check("fill3_full", 64'(bus_a.fifo_full), 64'd0);
        step_a(64'h44, 1'b1, 1'b0);
        check("fill4_count", 64'(bus_a.count), 64'd4);
        check("fill4_full", 64'(bus_a.fifo_full), 64'd1);
        step_a(64'h0, 1'b0, 1'b1);
        check("pop1_dout", bus_a.data_out, 64'h11);
        check("pop1_dvalid", 64'(bus_a.data_out_valid), 64'd1);
        step_a(64'h0, 1'b0, 1'b1);
        check("pop2_dout", bus_a.data_out, 64'h22);
        check("pop2_dvalid", 64'(bus_a.data_out_valid), 64'd1);
        step_a(64'h0, 1'b0, 1'b1);
        check("pop3_dout", bus_a.data_out, 64'h33);
        step_a(64'h0, 1'b0, 1'b1);
        check("pop4_dout", bus_a.data_out, 64'h44);
        check("pop4_dvalid", 64'(bus_a.data_out_valid), 64'd1);
        check("pop4_empty", 64'(bus_a.fifo_empty), 64'd1);
        check("pop4_err", 64'(bus_a.err), 64'd0);
        step_a(64'h0, 1'b0, 1'b0);
        check("idle_dvalid", 64'(bus_a.data_out_valid), 64'd0);
        check("idle_hold", bus_a.data_out, 64'h44);

        // Full FIFO with simultaneous push and pop.
        step_a(64'h11, 1'b1, 1'b0);
        step_a(64'h22, 1'b1, 1'b0);
        step_a(64'h33, 1'b1, 1'b0);
        step_a(64'h44, 1'b1, 1'b0);
        step_a(64'h55, 1'b1, 1'b1);
        check("pp_dout", bus_a.data_out, 64'h11);
        check("pp_count", 64'(bus_a.count), 64'd4);
        check("pp_full", 64'(bus_a.fifo_full), 64'd1);
        check("pp_err", 64'(bus_a.err), 64'd0);
        step_a(64'h0, 1'b0, 1'b1);
        check("pp_d1", bus_a.data_out, 64'h22);
        step_a(64'h0, 1'b0, 1'b1);
        check("pp_d2", bus_a.data_out, 64'h33);
        step_a(64'h0, 1'b0, 1'b1);
        check("pp_d3", bus_a.data_out, 64'h44);
        step_a(64'h0, 1'b0, 1'b1);
        check("pp_d4", bus_a.data_out, 64'h55);
        check("pp_empty", 64'(bus_a.fifo_empty), 64'd1);

        // Overflow drops the word and sets the sticky error.
        step_a(64'h61, 1'b1, 1'b0);
        step_a(64'h62, 1'b1, 1'b0);
        step_a(64'h63, 1'b1, 1'b0);
        step_a(64'h64, 1'b1, 1'b0);
        step_a(64'h99, 1'b1, 1'b0);
        check("ovf_err", 64'(bus_a.err), 64'd1);
        check("ovf_count", 64'(bus_a.count), 64'd4);
        step_a(64'h0, 1'b0, 1'b1);
        check("ovf_d1", bus_a.data_out, 64'h61);
        step_a(64'h0, 1'b0, 1'b1);
        check("ovf_d2", bus_a.data_out, 64'h62);
        step_a(64'h0, 1'b0, 1'b1);
        check("ovf_d3", bus_a.data_out, 64'h63);
        step_a(64'h0, 1'b0, 1'b1);
        check("ovf_d4", bus_a.data_out, 64'h64);
        check("ovf_empty", 64'(bus_a.fifo_empty), 64'd1);
        step_a(64'h0, 1'b0, 1'b0);
        check("ovf_sticky", 64'(bus_a.err), 64'd1);
        rst_a = 1'b0;
        #1;
        check("ovf_rst_err", 64'(bus_a.err), 64'd0);
        rst_a = 1'b1;

        // Underflow and empty push+pop.
        step_a(64'h0, 1'b0, 1'b1);
        check("udf_err", 64'(bus_a.err), 64'd1);
        check("udf_dvalid", 64'(bus_a.data_out_valid), 64'd0);
        check("udf_count", 64'(bus_a.count), 64'd0);
        step_a(64'hAA, 1'b1, 1'b1);
        check("epp_count", 64'(bus_a.count), 64'd1);
        check("epp_dvalid", 64'(bus_a.data_out_valid), 64'd0);
        step_a(64'h0, 1'b0, 1'b1);
        check("epp_dout", bus_a.data_out, 64'hAA);
        check("epp_dvalid1", 64'(bus_a.data_out_valid), 64'd1);
        check("epp_empty", 64'(bus_a.fifo_empty), 64'd1);

        // DEPTH=5 interleaved stream crossing pointer wrap twice.
        pushed = 0;
        for (int k = 0; k < 60 && (pushed < 13 || q.size() > 0); k++) begin
            pu = (pushed < 13) && (k % 4 != 3);
            po = (q.size() > 0) && ((k % 3 == 1) || (pushed >= 13));
            if (pu && !po && q.size() == 5) pu = 1'b0;
            step_b(8'(8'h30 + pushed), pu, po);
            if (po) begin
                exp_b = q.pop_front();
                check("b_dout", 64'(bus_b.data_out), 64'(exp_b));
                check("b_dvalid1", 64'(bus_b.data_out_valid), 64'd1);
            end else begin
                check("b_dvalid0", 64'(bus_b.data_out_valid), 64'd0);
            end
            if (pu) begin
                q.push_back(8'(8'h30 + pushed));
                pushed++;
            end
            check("b_count", 64'(bus_b.count), 64'(q.size()));
        end
        check("b_done", 64'(pushed), 64'd13);
        check("b_err", 64'(bus_b.err), 64'd0);
        check("b_empty", 64'(bus_b.fifo_empty), 64'd1);

        // Asynchronous reset mid-stream.
        step_b(8'hA1, 1'b1, 1'b0);
        step_b(8'hA2, 1'b1, 1'b0);
        step_b(8'hA3, 1'b1, 1'b0);
        step_b(8'h00, 1'b0, 1'b1);
        check("b_pre_dvalid", 64'(bus_b.data_out_valid), 64'd1);
        check("b_pre_count", 64'(bus_b.count), 64'd2);
        rst_b = 1'b0;
        #1;
        check("b_rst_count", 64'(bus_b.count), 64'd0);
        check("b_rst_empty", 64'(bus_b.fifo_empty), 64'd1);
        check("b_rst_dvalid", 64'(bus_b.data_out_valid), 64'd0);
        check("b_rst_dout", 64'(bus_b.data_out), 64'd0);
        rst_b = 1'b1;
        step_b(8'h00, 1'b0, 1'b1);
        check("b_post_dvalid", 64'(bus_b.data_out_valid), 64'd0);
        check("b_post_count", 64'(bus_b.count), 64'd0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO, the successor to the fixed 64-bit, 4-entry shift FIFO. It generalises data width and depth and stores entries in a circular buffer with read/write pointers instead of shifting. It also adds simultaneous push/pop, an occupancy count, an almost-full flag and a sticky error flag. It sits between producer and consumer stages of the datapath.

## Interface
- WIDTH, 64, data word width in bits (≥1)
- DEPTH, 4, number of entries (≥2; need not be a power of two)
- AFULL_THRESH, DEPTH-1, almost_full asserts when count ≥ AFULL_THRESH (1..DEPTH)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-low; asserting it low clears all state immediately
- data_in  in  WIDTH  write data
- data_in_valid  in  1  push request
- pop_fifo  in  1  pop request
- data_out  out  WIDTH  read data
- data_out_valid  out  1  data_out holds a popped word (meaning depends on mode, see Configuration)
- fifo_empty  out  1  count == 0
- fifo_full  out  1  count == DEPTH
- almost_full  out  1  count ≥ AFULL_THRESH
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
- err  out  1  sticky overflow/underflow flag

## Operation
- Storage: DEPTH×WIDTH register array, write pointer wp, read pointer rp, both in 0..DEPTH-1.
  - A pointer wraps from DEPTH-1 to 0.
  - Explicit compare is used, not modulo-2ⁿ, so any DEPTH works.
- Push accepted: data_in_valid && (!fifo_full || pop_accepted).
  - mem[wp] ← data_in; wp advances.
- Pop accepted: pop_fifo && !fifo_empty; rp advances.
- Count update:
  - +1 on push only
  - −1 on pop only
  - unchanged on both or neither
- Full + push + pop, same cycle: both accepted, count stays DEPTH, no error.
- Empty + push + pop, same cycle: push accepted, pop rejected (underflow), count becomes 1. There is no write-to-read bypass.
- Overflow: data_in_valid while full and no pop accepted → data dropped, contents unchanged, err set.
- Underflow: pop_fifo while empty → ignored, err set.
- err stays set until reset; no other clear.
- Flags (fifo_empty, fifo_full, almost_full, count) are registered or derived only from registered count. They have no combinational path from inputs.

## Timing
- Reset values (rst low):
  - wp = rp = 0, count = 0
  - fifo_empty = 1, fifo_full = 0, almost_full = 0, err = 0
  - data_out = 0, data_out_valid = 0
  - Array contents are not reset.
- Deasserting rst takes effect at the next clk edge.
- rst asserted mid-operation discards all stored entries; an in-flight data_out_valid pulse is cleared.
- Push/pop accepted at edge N: count and flags reflect the change after edge N, so they are visible in cycle N+1.
- Registered mode (default):
  - Pop accepted at edge N → data_out = popped word and data_out_valid = 1 during cycle N+1.
  - data_out_valid drops after one cycle unless another pop is accepted.
  - data_out holds its last value when valid is low.
  - Back-to-back pops give one word per cycle.
- Latency, push to poppable: a word pushed at edge N can be popped at edge N+1 (registered mode), with data_out_valid in cycle N+2.

## Configuration
- FIFO_FWFT_EN defined (first-word fall-through):
  - data_out = mem[rp] combinationally whenever !fifo_empty.
  - data_out_valid = !fifo_empty.
  - pop_fifo acknowledges the presented word and advances rp at the edge.
  - A word pushed at edge N is visible on data_out in cycle N+1.
  - When empty, data_out is don't-care.
- FIFO_FWFT_EN undefined: registered-output behaviour as described in Timing.
- Reset values are identical in both modes.

## Test plan
- Reset, then push 0x11, 0x22, 0x33, 0x44 (DEPTH=4) → count 4, fifo_full=1, almost_full=1 (from count 3); pop ×4 → data_out 0x11, 0x22, 0x33, 0x44 on consecutive cycles with data_out_valid=1 each cycle, then fifo_empty=1, err=0.
- Full FIFO, push 0x55 with pop_fifo=1 in the same cycle → 0x11 returned, count stays 4, err=0; the next four pops return 0x22, 0x33, 0x44, 0x55.
- Full FIFO, push 0x99 with no pop → err=1, count 4, and the drained sequence omits 0x99; err remains 1 until rst is pulled low.
- Empty FIFO, pop_fifo=1 → err=1, data_out_valid=0, count 0; empty + push 0xAA + pop in the same cycle → count 1, next pop returns 0xAA.
- DEPTH=5, WIDTH=8: push/pop 13 words in an interleaved pattern crossing pointer wrap twice → output order matches input order, count tracks the scoreboard; rst pulled low mid-stream clears count, flags and data_out_valid immediately, without waiting for a clock edge.
- FIFO_FWFT_EN defined: push 0x7 at edge N → data_out=0x7, data_out_valid=1 in cycle N+1 without a pop; pop → fifo_empty=1, data_out_valid=0.
